rs_multi: RTL and testbench
===========================

# rs_multi

Parametrised multi-issue reservation station, the successor to the single-issue RS. Sits between decoder/fetcher and `ISSUE_W` ALUs. Holds `DEPTH` entries and wakes operands from `CDB_N` broadcast buses, including a same-cycle bypass at insert. Each cycle it issues up to `ISSUE_W` ready entries, oldest first, each lane gated by ALU backpressure, and flushes all entries on ROB misprediction.

## Interface
Parameters:
- `DEPTH` = 16: entries; all slots usable, slot 0 included.
- `ISSUE_W` = 2: issue lanes.
- `CDB_N` = 3: wakeup buses (ALU, LSB, ROB).
- `XLEN` = 32: data width.
- `ROB_W` = 5: ROB tag width; tag `ZERO_ROB` (0) means "operand present".
- `OP_W` = 6: opcode width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state and outputs.
- `in_valid` in 1: insert request.
- `in_op` in OP_W, `in_rob` in ROB_W, `in_pc`/`in_imm` in XLEN: entry fields.
- `in_v1`/`in_v2` in XLEN, `in_q1`/`in_q2` in ROB_W: operand values and producer tags.
- `in_cdb_valid` in CDB_N: per-bus broadcast valid.
- `in_cdb_tag` in CDB_N*ROB_W, `in_cdb_value` in CDB_N*XLEN: packed bus tags and values, bus b at slice b.
- `in_alu_ready` in ISSUE_W: lane k may receive an op this cycle.
- `in_flush` in 1: ROB misprediction.
- `out_full` out 1: registered; high when all `DEPTH` entries are busy.
- `out_count` out clog2(DEPTH+1): busy entry count.
- `out_alu_valid` out ISSUE_W: per-lane issue pulse.
- `out_alu_op`, `out_alu_v1`, `out_alu_v2`, `out_alu_imm`, `out_alu_pc`, `out_alu_rob` out ISSUE_W*field: packed per-lane payloads.

## Operation
- Entry state: busy, op, rob, pc, imm, v1/q1, v2/q2, plus a DEPTH×DEPTH age matrix. `older[i][j]`=1 means entry i was inserted before entry j.
- Insert:
  - When `in_valid` and not full, write the lowest-index free slot and set its row older than every currently busy entry.
  - `in_valid` while `out_full` is a protocol violation. Assert on it; the request is dropped.
- Insert bypass: if `in_q1`/`in_q2` equals a valid CDB tag this cycle, store that bus value and tag 0.
- Wakeup: for each busy entry and each valid bus with tag≠0, a match on q1/q2 loads the value and clears the tag. Multiple buses matching the same tag must carry the same value; bus 0 wins.
- Ready: busy && q1==0 && q2==0, evaluated on registered state.
- Select:
  - Lane 0 takes the oldest ready entry. Lane k takes the oldest ready entry not taken by lanes 0..k-1.
  - A lane with `in_alu_ready[k]`=0 takes nothing, and its candidate stays available to the next enabled lane.
- Issue: the chosen entry's busy is cleared, and its payload is registered to lane k with `out_alu_valid[k]`=1 for exactly one cycle. Unused lanes drive valid=0 and op=`OPENUM_NOP`.
- Flush:
  - Clear all busy bits, q tags and age rows.
  - Force `out_alu_valid`=0 next cycle.
  - Flush dominates insert, issue and wakeup in the same cycle.
- `rdy`=0: no insert, issue, wakeup or flush is taken; registers hold. Inputs that cycle are lost; the producer holds them.

## Timing
- Reset (async, `rst`=0): all busy=0, `out_alu_valid`=0, payload outputs 0, `out_alu_op`=`OPENUM_NOP`, `out_count`=0, `out_full`=0.
- Insert with ready operands at edge t → eligible for selection in cycle t+1 → `out_alu_valid` high after edge t+1. Minimum latency is 2 edges.
- CDB wakeup at edge t → issuable at t+1. There is no same-cycle wakeup-to-issue.
- Insert and issue in the same cycle: count = count + inserted − issued.
  - `out_full` reflects the post-edge count.
  - A slot freed at edge t is reusable from cycle t+1.
- Insert bypass at full depth plus simultaneous wakeup of other entries: all take effect at the same edge.

## Structure
- Shared `definition.v` holds `ZERO_ROB`, `OPENUM_NOP`, opcode encodings and default widths.
- One sub-module, `rs_age_pick`: combinational, given a ready mask and the age matrix, returns a one-hot oldest entry. It is instantiated ISSUE_W times with progressively masked ready vectors.

## Test plan
- Reset mid-operation: with 5 busy entries, pulse `rst`=0 → next cycle count=0, full=0, all valid=0; inserts resume into slot 0.
- Oldest-first: insert A(q=0), B(q=0), C(q=0) on consecutive cycles, ISSUE_W=2, both ready → A and B issue together on lanes 0 and 1, C issues the next cycle.
- Wakeup/bypass:
  - Insert entry with q1=7 while CDB1 broadcasts tag 7, value 0x55 → entry issues 2 edges later with v1=0x55.
  - Entry q2=9, CDB2 tag 9 at edge t → issued at t+1.
- Backpressure: two ready entries, `in_alu_ready`=2'b01 → only lane 0 valid; second entry issues on lane 0 next cycle.
- Full: fill 16 entries with q1=3 → `out_full`=1; extra `in_valid` dropped and assertion fires. CDB tag 3 → issue 2 per cycle, `out_full` drops after the first issue edge.
- Flush: flush coincident with insert and a ready entry → no issue next cycle, count=0, inserted entry absent.

Source files
------------

// File: rtl/rs_multi_pkg.sv
// rs_multi_pkg: shared definitions for the multi-issue reservation station.
//   ZERO_ROB   - producer tag meaning "operand already present"
//   opcode_e   - ALU opcode encodings, OPENUM_NOP drives idle issue lanes
//   *_DEF      - default field widths
package rs_multi_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 5;
  localparam int OP_W_DEF  = 6;

  localparam logic [ROB_W_DEF-1:0] ZERO_ROB = '0;

  typedef enum logic [OP_W_DEF-1:0] {
    OPENUM_NOP  = 6'd0,
    OPENUM_ADD  = 6'd1,
    OPENUM_SUB  = 6'd2,
    OPENUM_AND  = 6'd3,
    OPENUM_OR   = 6'd4,
    OPENUM_XOR  = 6'd5,
    OPENUM_SLL  = 6'd6,
    OPENUM_SRL  = 6'd7,
    OPENUM_SRA  = 6'd8,
    OPENUM_SLT  = 6'd9,
    OPENUM_SLTU = 6'd10
  } opcode_e;

endpackage

// File: rtl/rs_age_pick.sv
// rs_age_pick: combinational oldest-entry picker.
//   ready_i [DEPTH]        - candidate entries
//   older_i [DEPTH*DEPTH]  - age matrix, bit i*DEPTH+j set when entry i is older than j
//   grant_o [DEPTH]        - one-hot oldest candidate, zero when no candidate
module rs_age_pick
  import rs_multi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]       ready_i,
  input  logic [DEPTH*DEPTH-1:0] older_i,
  output logic [DEPTH-1:0]       grant_o
);

  logic [DEPTH-1:0] blocked;

  // An entry loses if any other candidate is older than it.
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready_i[j] && older_i[j*DEPTH + i]) blocked[i] = 1'b1;
      end
    end
    grant_o = ready_i & ~blocked;
  end

endmodule

// File: rtl/rs_multi.sv
// rs_multi: multi-issue reservation station.
//   clk, rst (async active-low), rdy (global enable, low freezes everything)
//   in_valid/in_op/in_rob/in_pc/in_imm/in_v1/in_q1/in_v2/in_q2 - insert request
//   in_cdb_valid/in_cdb_tag/in_cdb_value - CDB_N packed wakeup buses
//   in_alu_ready - per-lane backpressure, in_flush - ROB misprediction
//   out_full/out_count - registered occupancy
//   out_alu_* - registered per-lane issue pulse and packed payloads
module rs_multi
  import rs_multi_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ISSUE_W   = 2,
  parameter int CDB_N     = 3,
  parameter int XLEN      = XLEN_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter bit ASSERT_EN = 1'b1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [ROB_W-1:0]         in_rob,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [XLEN-1:0]          in_v1,
  input  logic [XLEN-1:0]          in_v2,
  input  logic [ROB_W-1:0]         in_q1,
  input  logic [ROB_W-1:0]         in_q2,
  input  logic [CDB_N-1:0]         in_cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]   in_cdb_tag,
  input  logic [CDB_N*XLEN-1:0]    in_cdb_value,
  input  logic [ISSUE_W-1:0]       in_alu_ready,
  input  logic                     in_flush,
  output logic                     out_full,
  output logic [CNT_W-1:0]         out_count,
  output logic [ISSUE_W-1:0]       out_alu_valid,
  output logic [ISSUE_W*OP_W-1:0]  out_alu_op,
  output logic [ISSUE_W*XLEN-1:0]  out_alu_v1,
  output logic [ISSUE_W*XLEN-1:0]  out_alu_v2,
  output logic [ISSUE_W*XLEN-1:0]  out_alu_imm,
  output logic [ISSUE_W*XLEN-1:0]  out_alu_pc,
  output logic [ISSUE_W*ROB_W-1:0] out_alu_rob
);

  localparam logic [ROB_W-1:0] ZR     = ROB_W'(ZERO_ROB);
  localparam logic [OP_W-1:0]  NOP_OP = OP_W'(OPENUM_NOP);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  v1;
    logic [ROB_W-1:0] q1;
    logic [XLEN-1:0]  v2;
    logic [ROB_W-1:0] q2;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
  } lane_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  lane_t            lane_q [ISSUE_W];
  lane_t            lane_d [ISSUE_W];
  logic [ISSUE_W-1:0] valid_q, valid_d;

  logic [DEPTH-1:0]       ready;
  logic [DEPTH*DEPTH-1:0] older_flat;
  logic [DEPTH-1:0]       avail [ISSUE_W];
  logic [DEPTH-1:0]       grant [ISSUE_W];
  logic [DEPTH-1:0]       take  [ISSUE_W];
  logic [DEPTH-1:0]       issue_mask;
  logic [DEPTH-1:0]       free_slots, ins_oh;
  logic                   do_ins;
  logic [XLEN-1:0]        ins_v1, ins_v2;
  logic [ROB_W-1:0]       ins_q1, ins_q2;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (entry_q[i].q1 == ZR) && (entry_q[i].q2 == ZR);
      older_flat[i*DEPTH +: DEPTH] = older_q[i];
    end
  end

  assign avail[0] = ready;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    rs_age_pick #(.DEPTH(DEPTH)) u_pick (
      .ready_i (avail[k]),
      .older_i (older_flat),
      .grant_o (grant[k])
    );
    // A stalled lane leaves its candidate in the pool for the next lane.
    assign take[k] = in_alu_ready[k] ? grant[k] : '0;
    if (k < ISSUE_W - 1) begin : g_mask
      assign avail[k+1] = avail[k] & ~take[k];
    end
    assign out_alu_op [k*OP_W  +: OP_W]  = lane_q[k].op;
    assign out_alu_rob[k*ROB_W +: ROB_W] = lane_q[k].rob;
    assign out_alu_pc [k*XLEN  +: XLEN]  = lane_q[k].pc;
    assign out_alu_imm[k*XLEN  +: XLEN]  = lane_q[k].imm;
    assign out_alu_v1 [k*XLEN  +: XLEN]  = lane_q[k].v1;
    assign out_alu_v2 [k*XLEN  +: XLEN]  = lane_q[k].v2;
  end

  assign free_slots = ~busy_q;
  assign ins_oh     = free_slots & (~free_slots + 1'b1);
  assign do_ins     = in_valid && !full_q && !in_flush;

  // Same-cycle bypass; highest bus index first so bus 0 wins.
  always_comb begin
    ins_v1 = in_v1;
    ins_q1 = in_q1;
    ins_v2 = in_v2;
    ins_q2 = in_q2;
    for (int unsigned n = 0; n < CDB_N; n++) begin
      if (in_cdb_valid[CDB_N-1-n]) begin
        if (in_q1 != ZR && in_cdb_tag[(CDB_N-1-n)*ROB_W +: ROB_W] == in_q1) begin
          ins_v1 = in_cdb_value[(CDB_N-1-n)*XLEN +: XLEN];
          ins_q1 = ZR;
        end
        if (in_q2 != ZR && in_cdb_tag[(CDB_N-1-n)*ROB_W +: ROB_W] == in_q2) begin
          ins_v2 = in_cdb_value[(CDB_N-1-n)*XLEN +: XLEN];
          ins_q2 = ZR;
        end
      end
    end
  end

  always_comb begin
    issue_mask = '0;
    for (int unsigned k = 0; k < ISSUE_W; k++) issue_mask = issue_mask | take[k];
  end

  always_comb begin
    busy_d  = busy_q & ~issue_mask;
    entry_d = entry_q;
    older_d = older_q;

    // Wakeup compares against registered tags, so the bus-0 write lands last.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned n = 0; n < CDB_N; n++) begin
        if (busy_q[i] && in_cdb_valid[CDB_N-1-n]
            && in_cdb_tag[(CDB_N-1-n)*ROB_W +: ROB_W] != ZR) begin
          if (entry_q[i].q1 == in_cdb_tag[(CDB_N-1-n)*ROB_W +: ROB_W]) begin
            entry_d[i].v1 = in_cdb_value[(CDB_N-1-n)*XLEN +: XLEN];
            entry_d[i].q1 = ZR;
          end
          if (entry_q[i].q2 == in_cdb_tag[(CDB_N-1-n)*ROB_W +: ROB_W]) begin
            entry_d[i].v2 = in_cdb_value[(CDB_N-1-n)*XLEN +: XLEN];
            entry_d[i].q2 = ZR;
          end
        end
      end
    end

    // New entry is younger than everything currently busy.
    if (do_ins) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ins_oh[i]) begin
          busy_d[i]  = 1'b1;
          entry_d[i] = '{op: in_op, rob: in_rob, pc: in_pc, imm: in_imm,
                         v1: ins_v1, q1: ins_q1, v2: ins_v2, q2: ins_q2};
          older_d[i] = '0;
          for (int unsigned j = 0; j < DEPTH; j++) older_d[j][i] = busy_q[j];
        end
      end
    end

    if (in_flush) begin
      busy_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_d[i].q1 = ZR;
        entry_d[i].q2 = ZR;
        older_d[i]    = '0;
      end
    end

    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
    full_d = (cnt_d == CNT_W'(DEPTH));
  end

  always_comb begin
    valid_d = '0;
    for (int unsigned k = 0; k < ISSUE_W; k++) begin
      lane_d[k]    = '0;
      lane_d[k].op = NOP_OP;
      if (!in_flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (take[k][i]) begin
            valid_d[k] = 1'b1;
            lane_d[k]  = '{op: entry_q[i].op, rob: entry_q[i].rob, pc: entry_q[i].pc,
                           imm: entry_q[i].imm, v1: entry_q[i].v1, v2: entry_q[i].v2};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        older_q[i] <= '0;
      end
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
        lane_q[k]    <= '0;
        lane_q[k].op <= NOP_OP;
      end
    end else if (rdy) begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      entry_q <= entry_d;
      older_q <= older_d;
      lane_q  <= lane_d;
    end
  end

  assign out_full      = full_q;
  assign out_count     = cnt_q;
  assign out_alu_valid = valid_q;

  if (ASSERT_EN) begin : g_proto_chk
    a_no_insert_when_full: assert property (
      @(posedge clk) disable iff (!rst) (rdy && in_valid) |-> !full_q);
  end

endmodule

// File: tb/tb_rs_multi.sv
module tb_rs_multi;
  localparam int DEPTH   = 16;
  localparam int ISSUE_W = 2;
  localparam int CDB_N   = 3;
  localparam int XLEN    = 32;
  localparam int ROB_W   = 5;
  localparam int OP_W    = 6;
  localparam int CNT_W   = 5;

  logic clk = 1'b0;
  logic rst, rdy, in_valid, in_flush;
  logic [OP_W-1:0]  in_op;
  logic [ROB_W-1:0] in_rob, in_q1, in_q2;
  logic [XLEN-1:0]  in_pc, in_imm, in_v1, in_v2;
  logic [CDB_N-1:0]       in_cdb_valid;
  logic [CDB_N*ROB_W-1:0] in_cdb_tag;
  logic [CDB_N*XLEN-1:0]  in_cdb_value;
  logic [ISSUE_W-1:0]     in_alu_ready;
  logic                   out_full;
  logic [CNT_W-1:0]       out_count;
  logic [ISSUE_W-1:0]     out_alu_valid;
  logic [ISSUE_W*OP_W-1:0]  out_alu_op;
  logic [ISSUE_W*XLEN-1:0]  out_alu_v1, out_alu_v2, out_alu_imm, out_alu_pc;
  logic [ISSUE_W*ROB_W-1:0] out_alu_rob;

  int checks = 0;
  int errors = 0;

  rs_multi #(
    .DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .CDB_N(CDB_N), .XLEN(XLEN),
    .ROB_W(ROB_W), .OP_W(OP_W), .ASSERT_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid),
    .in_op(in_op), .in_rob(in_rob), .in_pc(in_pc), .in_imm(in_imm),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_alu_ready(in_alu_ready), .in_flush(in_flush),
    .out_full(out_full), .out_count(out_count), .out_alu_valid(out_alu_valid),
    .out_alu_op(out_alu_op), .out_alu_v1(out_alu_v1), .out_alu_v2(out_alu_v2),
    .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc), .out_alu_rob(out_alu_rob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = '0; in_rob = '0; in_pc = '0; in_imm = '0;
    in_v1 = '0; in_v2 = '0; in_q1 = '0; in_q2 = '0;
    in_cdb_valid = '0; in_cdb_tag = '0; in_cdb_value = '0;
    in_flush = 1'b0;
  endtask

  task automatic put(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                     input logic [XLEN-1:0] v1, input logic [ROB_W-1:0] q1,
                     input logic [XLEN-1:0] v2, input logic [ROB_W-1:0] q2);
    in_valid = 1'b1; in_op = op; in_rob = rob;
    in_pc = 32'h1000 + 32'(rob); in_imm = 32'h200 + 32'(rob);
    in_v1 = v1; in_q1 = q1; in_v2 = v2; in_q2 = q2;
  endtask

  task automatic cdb(input int b, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] val);
    in_cdb_valid[b] = 1'b1;
    in_cdb_tag[b*ROB_W +: ROB_W] = tag;
    in_cdb_value[b*XLEN +: XLEN] = val;
  endtask

  task automatic occ(input string tag, input int cnt, input logic full);
    check({tag, ".count"}, 64'(out_count), 64'(cnt));
    check({tag, ".full"}, 64'(out_full), 64'(full));
  endtask

  // Expected pc/imm follow the put() convention derived from the rob tag.
  task automatic lane(input string tag, input int k, input logic v, input logic [OP_W-1:0] op,
                      input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] v1,
                      input logic [XLEN-1:0] v2);
    check({tag, ".valid"}, 64'(out_alu_valid[k]), 64'(v));
    if (v) begin
      check({tag, ".op"},  64'(out_alu_op[k*OP_W +: OP_W]), 64'(op));
      check({tag, ".rob"}, 64'(out_alu_rob[k*ROB_W +: ROB_W]), 64'(rob));
      check({tag, ".v1"},  64'(out_alu_v1[k*XLEN +: XLEN]), 64'(v1));
      check({tag, ".v2"},  64'(out_alu_v2[k*XLEN +: XLEN]), 64'(v2));
      check({tag, ".pc"},  64'(out_alu_pc[k*XLEN +: XLEN]), 64'(32'h1000 + 32'(rob)));
      check({tag, ".imm"}, 64'(out_alu_imm[k*XLEN +: XLEN]), 64'(32'h200 + 32'(rob)));
    end else begin
      check({tag, ".nop"}, 64'(out_alu_op[k*OP_W +: OP_W]), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; in_alu_ready = '0;
    idle();
    step();
    occ("reset", 0, 1'b0);
    lane("reset.l0", 0, 1'b0, 0, 0, 0, 0);
    lane("reset.l1", 1, 1'b0, 0, 0, 0, 0);
    check("reset.pc0", 64'(out_alu_pc[31:0]), 64'(0));
    rst = 1'b1;

    // Oldest first across two lanes
    put(6'd1, 5'd1, 32'h11, 0, 32'h12, 0); step(); occ("age.ins1", 1, 1'b0);
    lane("age.ins1.l0", 0, 1'b0, 0, 0, 0, 0);
    put(6'd2, 5'd2, 32'h21, 0, 32'h22, 0); step(); occ("age.ins2", 2, 1'b0);
    put(6'd3, 5'd3, 32'h31, 0, 32'h32, 0); step(); occ("age.ins3", 3, 1'b0);
    idle(); in_alu_ready = 2'b11; step();
    lane("age.i1.l0", 0, 1'b1, 6'd1, 5'd1, 32'h11, 32'h12);
    lane("age.i1.l1", 1, 1'b1, 6'd2, 5'd2, 32'h21, 32'h22);
    occ("age.i1", 1, 1'b0);
    step();
    lane("age.i2.l0", 0, 1'b1, 6'd3, 5'd3, 32'h31, 32'h32);
    lane("age.i2.l1", 1, 1'b0, 0, 0, 0, 0);
    occ("age.i2", 0, 1'b0);
    step();
    lane("age.i3.l0", 0, 1'b0, 0, 0, 0, 0);

    // Insert bypass from CDB1
    put(6'd5, 5'd4, 32'hDEAD, 5'd7, 32'h66, 0); cdb(1, 5'd7, 32'h55); step();
    lane("byp.ins.l0", 0, 1'b0, 0, 0, 0, 0); occ("byp.ins", 1, 1'b0);
    idle(); step();
    lane("byp.iss.l0", 0, 1'b1, 6'd5, 5'd4, 32'h55, 32'h66); occ("byp.iss", 0, 1'b0);

    // Wakeup from CDB2, issue one edge after the broadcast
    put(6'd4, 5'd5, 32'h1, 0, 32'hBEEF, 5'd9); step(); occ("wk.ins", 1, 1'b0);
    idle(); step(); lane("wk.wait.l0", 0, 1'b0, 0, 0, 0, 0);
    cdb(2, 5'd9, 32'h99); step();
    lane("wk.bcast.l0", 0, 1'b0, 0, 0, 0, 0); occ("wk.bcast", 1, 1'b0);
    idle(); step();
    lane("wk.iss.l0", 0, 1'b1, 6'd4, 5'd5, 32'h1, 32'h99); occ("wk.iss", 0, 1'b0);

    // Backpressure on lane 1, then on lane 0
    in_alu_ready = 2'b00;
    put(6'd1, 5'd6, 32'h61, 0, 32'h62, 0); step();
    put(6'd1, 5'd7, 32'h71, 0, 32'h72, 0); step();
    idle(); in_alu_ready = 2'b01; step();
    lane("bp0.a.l0", 0, 1'b1, 6'd1, 5'd6, 32'h61, 32'h62);
    lane("bp0.a.l1", 1, 1'b0, 0, 0, 0, 0); occ("bp0.a", 1, 1'b0);
    step();
    lane("bp0.b.l0", 0, 1'b1, 6'd1, 5'd7, 32'h71, 32'h72); occ("bp0.b", 0, 1'b0);
    in_alu_ready = 2'b00;
    put(6'd2, 5'd8, 32'h81, 0, 32'h82, 0); step();
    put(6'd2, 5'd9, 32'h91, 0, 32'h92, 0); step();
    idle(); in_alu_ready = 2'b10; step();
    lane("bp1.a.l0", 0, 1'b0, 0, 0, 0, 0);
    lane("bp1.a.l1", 1, 1'b1, 6'd2, 5'd8, 32'h81, 32'h82);
    step();
    lane("bp1.b.l1", 1, 1'b1, 6'd2, 5'd9, 32'h91, 32'h92); occ("bp1.b", 0, 1'b0);

    // Reused slot 0 must be younger than the surviving entry
    in_alu_ready = 2'b00;
    put(6'd3, 5'd10, 32'hA1, 0, 32'hA2, 0); step();
    put(6'd3, 5'd11, 32'hB1, 0, 32'hB2, 0); step();
    idle(); in_alu_ready = 2'b01; step();
    lane("reuse.a.l0", 0, 1'b1, 6'd3, 5'd10, 32'hA1, 32'hA2);
    in_alu_ready = 2'b00;
    put(6'd3, 5'd12, 32'hC1, 0, 32'hC2, 0); step(); occ("reuse.ins", 2, 1'b0);
    idle(); in_alu_ready = 2'b01; step();
    lane("reuse.b.l0", 0, 1'b1, 6'd3, 5'd11, 32'hB1, 32'hB2);
    step();
    lane("reuse.c.l0", 0, 1'b1, 6'd3, 5'd12, 32'hC1, 32'hC2); occ("reuse.c", 0, 1'b0);

    // Fill to full, drop an extra insert, then drain two per cycle
    in_alu_ready = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      put(6'd1, 5'(i + 1), 32'h0, 5'd3, 32'(i), 0);
      step();
      if (i == DEPTH - 2) occ("full.fill15", DEPTH - 1, 1'b0);
    end
    occ("full.fill16", DEPTH, 1'b1);
    put(6'd1, 5'd31, 32'h0, 0, 32'h0, 0); step();
    occ("full.drop", DEPTH, 1'b1);
    idle(); cdb(0, 5'd3, 32'h33); in_alu_ready = 2'b11; step();
    occ("full.wake", DEPTH, 1'b1); lane("full.wake.l0", 0, 1'b0, 0, 0, 0, 0);
    idle(); step();
    lane("full.i0.l0", 0, 1'b1, 6'd1, 5'd1, 32'h33, 32'd0);
    lane("full.i0.l1", 1, 1'b1, 6'd1, 5'd2, 32'h33, 32'd1);
    occ("full.i0", DEPTH - 2, 1'b0);
    rdy = 1'b0; step();
    occ("frz", DEPTH - 2, 1'b0);
    lane("frz.l0", 0, 1'b1, 6'd1, 5'd1, 32'h33, 32'd0);
    rdy = 1'b1;
    for (int n = 0; n < 7; n++) begin
      step();
      lane("drain.l0", 0, 1'b1, 6'd1, 5'(3 + 2*n), 32'h33, 32'(2 + 2*n));
      lane("drain.l1", 1, 1'b1, 6'd1, 5'(4 + 2*n), 32'h33, 32'(3 + 2*n));
      occ("drain", DEPTH - 4 - 2*n, 1'b0);
    end
    step();
    lane("drain.end.l0", 0, 1'b0, 0, 0, 0, 0);

    // Flush beats a ready issue and a same-cycle insert
    in_alu_ready = 2'b00;
    put(6'd6, 5'd20, 32'hE1, 0, 32'hE2, 0); step(); occ("fl.pre", 1, 1'b0);
    put(6'd6, 5'd21, 32'hF1, 0, 32'hF2, 0); in_flush = 1'b1; in_alu_ready = 2'b11; step();
    occ("fl.edge", 0, 1'b0);
    lane("fl.edge.l0", 0, 1'b0, 0, 0, 0, 0);
    lane("fl.edge.l1", 1, 1'b0, 0, 0, 0, 0);
    idle(); step();
    occ("fl.after", 0, 1'b0); lane("fl.after.l0", 0, 1'b0, 0, 0, 0, 0);
    put(6'd7, 5'd22, 32'h7, 0, 32'h8, 0); step();
    idle(); step();
    lane("fl.resume.l0", 0, 1'b1, 6'd7, 5'd22, 32'h7, 32'h8);

    // Reset in the middle of operation
    in_alu_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      put(6'd2, 5'(i + 1), 32'h0, 0, 32'h0, 0);
      step();
    end
    occ("rst.pre", 5, 1'b0);
    idle(); rst = 1'b0; step();
    occ("rst.mid", 0, 1'b0);
    lane("rst.mid.l0", 0, 1'b0, 0, 0, 0, 0);
    lane("rst.mid.l1", 1, 1'b0, 0, 0, 0, 0);
    rst = 1'b1; in_alu_ready = 2'b11;
    put(6'd8, 5'd9, 32'h90, 0, 32'h91, 0); step(); occ("rst.ins", 1, 1'b0);
    idle(); step();
    lane("rst.iss.l0", 0, 1'b1, 6'd8, 5'd9, 32'h90, 32'h91); occ("rst.iss", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
